// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Sequential RV32M unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// Each of the 32 iterations borrows the shared 32-bit ALU for one add
// (multiply) or subtract (divide). The ALU is requested with o_alu_req while
// calculating; an iteration only commits on an edge where i_alu_gnt is high.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (ready only when idle)
//   i_req_op                0=MUL, 1=MULHU, 2=DIVU, 3=REMU
//   i_req_a, i_req_b        multiplicand/dividend, multiplier/divisor
//   o_rsp_valid/i_rsp_ready response handshake (valid only when done)
//   o_rsp_data              registered result, stable while valid
//   o_alu_req/i_alu_gnt     shared ALU request/grant
//   o_alu_op_a/_b, o_alu_op ALU operands and select (0=add, 1=sub)
//   i_alu_data              combinational ALU result
// -----------------------------------------------------------------------------
module muldiv_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_alu_req,
  input  logic        i_alu_gnt,
  output logic [31:0] o_alu_op_a,
  output logic [31:0] o_alu_op_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // r_acc holds HI (multiply) or the remainder R (divide).
  // r_sh  holds LO (multiply) or the quotient/dividend shift register Q.
  // r_opnd holds the multiplicand M or the divisor D.
  logic [1:0]  r_op;
  logic [31:0] r_acc;
  logic [31:0] r_sh;
  logic [31:0] r_opnd;
  logic [4:0]  r_cnt;
  logic [31:0] r_rsp_data;

  logic        w_div;
  logic        w_accept;
  logic        w_commit;
  logic [31:0] w_rshift;
  logic        w_carry;
  logic        w_ge;
  logic [31:0] w_acc_next;
  logic [31:0] w_sh_next;
  logic [31:0] w_result;

  assign w_div    = r_op[1];
  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_commit = (r_state == S_CALC) && i_alu_gnt;
  // Remainder shifted left by one with the next dividend bit brought in.
  assign w_rshift = {r_acc[30:0], r_sh[31]};

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and all handshake/ALU outputs
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_alu_req    = 1'b0;
    o_alu_op_a   = 32'd0;
    o_alu_op_b   = 32'd0;
    o_alu_op     = 4'd0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        o_alu_req = 1'b1;
        if (w_div) begin
          o_alu_op_a = w_rshift;
          o_alu_op_b = r_opnd;
          o_alu_op   = 4'd1;
        end else begin
          o_alu_op_a = r_acc;
          o_alu_op_b = r_sh[0] ? r_opnd : 32'd0;
          o_alu_op   = 4'd0;
        end
        if (i_alu_gnt && (r_cnt == 5'd31)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Iteration arithmetic. The carry out of HI+op_b and the "R' >= D" test are
  // reconstructed from operand MSBs and the sum MSB, since the ALU only
  // returns 32 bits.
  always_comb begin
    w_carry = (r_acc[31] & o_alu_op_b[31]) |
              ((r_acc[31] | o_alu_op_b[31]) & ~i_alu_data[31]);
    // r_acc[31] is the bit shifted out of R'; if set, R' is at least 2^32.
    w_ge    = r_acc[31] |
              (w_rshift[31] & ~r_opnd[31]) |
              (~(w_rshift[31] ^ r_opnd[31]) & ~i_alu_data[31]);
    if (w_div) begin
      w_acc_next = w_ge ? i_alu_data : w_rshift;
      w_sh_next  = {r_sh[30:0], w_ge};
    end else begin
      w_acc_next = {w_carry, i_alu_data[31:1]};
      w_sh_next  = {i_alu_data[0], r_sh[31:1]};
    end
    // MUL/DIVU take the low/quotient register, MULHU/REMU the high/remainder.
    w_result = r_op[0] ? w_acc_next : w_sh_next;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op       <= 2'd0;
      r_acc      <= 32'd0;
      r_sh       <= 32'd0;
      r_opnd     <= 32'd0;
      r_cnt      <= 5'd0;
      r_rsp_data <= 32'd0;
    end else if (w_accept) begin
      r_op   <= i_req_op;
      r_acc  <= 32'd0;
      r_sh   <= i_req_op[1] ? i_req_a : i_req_b;
      r_opnd <= i_req_op[1] ? i_req_b : i_req_a;
      r_cnt  <= 5'd0;
    end else if (w_commit) begin
      r_acc <= w_acc_next;
      r_sh  <= w_sh_next;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_rsp_data <= w_result;
      end
    end
  end

  assign o_rsp_data = r_rsp_data;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [1:0]  i_req_op = 2'd0;
  logic [31:0] i_req_a = 32'd0;
  logic [31:0] i_req_b = 32'd0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_data;
  logic        o_alu_req;
  logic        i_alu_gnt = 1'b0;
  logic [31:0] o_alu_op_a;
  logic [31:0] o_alu_op_b;
  logic [3:0]  o_alu_op;
  logic [31:0] i_alu_data;

  int tests = 0;
  int fails = 0;

  muldiv_seq dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_alu_req   (o_alu_req),
    .i_alu_gnt   (i_alu_gnt),
    .o_alu_op_a  (o_alu_op_a),
    .o_alu_op_b  (o_alu_op_b),
    .o_alu_op    (o_alu_op),
    .i_alu_data  (i_alu_data)
  );

  always #5 i_clk = ~i_clk;

  // Shared ALU seen by the block
  always_comb begin
    i_alu_data = (o_alu_op == 4'd1) ? (o_alu_op_a - o_alu_op_b) : (o_alu_op_a + o_alu_op_b);
  end

  // Reference model: plain 64-bit arithmetic with RV32M divide-by-zero rules
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drives one transaction. mode: 0=grant high, 1=grant toggling, 2=random grant.
  // lat counts cycles from the request cycle to the first valid cycle.
  // viol counts ungranted-cycle operand changes and DONE hold/exit errors.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int rsp_delay,
                        output logic [31:0] res, output int lat, output int req_cycles,
                        output int viol, output bit tout);
    int n;
    logic [31:0] pa, pb;
    logic [3:0]  po;
    bit plow;
    res = 32'd0; lat = 0; req_cycles = 0; viol = 0; tout = 1'b0;
    pa = 32'd0; pb = 32'd0; po = 4'd0; plow = 1'b0;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    if (!o_req_ready) begin
      tout = 1'b1;
      return;
    end
    i_req_valid = 1'b1; i_req_op = op; i_req_a = a; i_req_b = b;
    i_alu_gnt = (mode == 0) ? 1'b1 : 1'($urandom % 2);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 400) begin
      if (plow && (o_alu_req !== 1'b1 || o_alu_op_a !== pa || o_alu_op_b !== pb || o_alu_op !== po))
        viol++;
      if (o_alu_req) req_cycles++;
      if (mode == 0) i_alu_gnt = 1'b1;
      else if (mode == 1) i_alu_gnt = ~i_alu_gnt;
      else i_alu_gnt = 1'($urandom % 2);
      plow = o_alu_req && !i_alu_gnt;
      pa = o_alu_op_a; pb = o_alu_op_b; po = o_alu_op;
      @(posedge i_clk); #1;
      lat++;
    end
    if (!o_rsp_valid) begin
      tout = 1'b1;
      return;
    end
    res = o_rsp_data;
    for (int k = 0; k < rsp_delay; k++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0 || o_rsp_data !== res) viol++;
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) viol++;
    $display("[TB] txn op=%0d a=%08h b=%08h -> %08h lat=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_alu_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: ready=%b valid=%b alu_req=%b, required 1/0/0", o_req_ready, o_rsp_valid, o_alu_req);
    end
    tests++;
    if (o_rsp_data !== 32'd0 || o_alu_op_a !== 32'd0 || o_alu_op_b !== 32'd0 || o_alu_op !== 4'd0) begin
      fails++;
      $display("FAIL reset_data: rsp=%h a=%h b=%h op=%h, required all zero", o_rsp_data, o_alu_op_a, o_alu_op_b, o_alu_op);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_mul_basic();
    logic [31:0] r; int lat, rc, v; bit t;
    run_op(2'd0, 32'd7, 32'd6, 0, 0, r, lat, rc, v, t);
    tests++;
    if (t !== 1'b0 || r !== 32'h0000_002A) begin
      fails++;
      $display("FAIL mul_7x6: got %h timeout=%0b, required 0000002a", r, t);
    end
    tests++;
    if (lat != 33) begin
      fails++;
      $display("FAIL mul_latency: got %0d, required 33", lat);
    end
    tests++;
    if (rc != 32) begin
      fails++;
      $display("FAIL mul_alu_req_cycles: got %0d, required 32", rc);
    end
    tests++;
    if (v != 0) begin
      fails++;
      $display("FAIL mul_handshake: %0d violations, required 0", v);
    end
  endtask

  task automatic test_mulhu_ones();
    logic [31:0] r; int lat, rc, v; bit t;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r, lat, rc, v, t);
    tests++;
    if (t !== 1'b0 || r !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL mulhu_ones: got %h, required fffffffe", r);
    end
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, r, lat, rc, v, t);
    tests++;
    if (t !== 1'b0 || r !== 32'h0000_0001) begin
      fails++;
      $display("FAIL mul_ones: got %h, required 00000001", r);
    end
  endtask

  task automatic test_div_vectors();
    logic [1:0]  ops [5] = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'd100, 32'd100, 32'h8000_0000, 32'h1234, 32'h1234};
    logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd3, 32'd0, 32'd0};
    logic [31:0] exp [5] = '{32'd14, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h0000_1234};
    logic [31:0] r; int lat, rc, v; bit t;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 0, 1, r, lat, rc, v, t);
      tests++;
      if (t !== 1'b0 || r !== exp[i] || v != 0) begin
        fails++;
        $display("FAIL div_vec%0d: got %h viol=%0d, required %h", i, r, v, exp[i]);
      end
    end
  endtask

  task automatic test_grant_toggle();
    logic [31:0] r; int lat, rc, v; bit t;
    for (int i = 0; i < 2; i++) begin
      run_op(2'(i), 32'h0001_0000, 32'h0001_0000, 1, 0, r, lat, rc, v, t);
      tests++;
      if (t !== 1'b0 || r !== ((i == 0) ? 32'd0 : 32'd1)) begin
        fails++;
        $display("FAIL toggle_result%0d: got %h, required %h", i, r, (i == 0) ? 32'd0 : 32'd1);
      end
      tests++;
      if (lat < 64 || lat > 65) begin
        fails++;
        $display("FAIL toggle_latency%0d: got %0d, required 64..65", i, lat);
      end
      tests++;
      if (v != 0) begin
        fails++;
        $display("FAIL toggle_stable%0d: %0d violations, required 0", i, v);
      end
    end
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] r, a, b; int lat, rc, v, bad; bit t;
    i_req_valid = 1'b1; i_req_op = 2'd2; i_req_a = 32'd1000; i_req_b = 32'd7;
    i_alu_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    repeat (10) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    #1;
    tests++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_alu_req !== 1'b0 ||
        o_alu_op_a !== 32'd0 || o_alu_op_b !== 32'd0 || o_alu_op !== 4'd0 || o_rsp_data !== 32'd0) begin
      fails++;
      $display("FAIL midcalc_reset: ready=%b valid=%b alu_req=%b a=%h b=%h rsp=%h, required idle outputs",
               o_req_ready, o_rsp_valid, o_alu_req, o_alu_op_a, o_alu_op_b, o_rsp_data);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL after_reset_idle: %0d non-idle cycles, required 0", bad);
    end
    a = $urandom; b = $urandom_range(1, 5000);
    run_op(2'd2, a, b, 0, 6, r, lat, rc, v, t);
    tests++;
    if (t !== 1'b0 || r !== ref_model(2'd2, a, b)) begin
      fails++;
      $display("FAIL followup_divu: got %h, required %h", r, ref_model(2'd2, a, b));
    end
    tests++;
    if (v != 0) begin
      fails++;
      $display("FAIL followup_hold: %0d violations in DONE, required 0", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, e; logic [1:0] op; int lat, rc, v; bit t;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom % 4);
      a = $urandom;
      case ($urandom % 4)
        0: b = 32'd0;
        1: b = $urandom_range(1, 255);
        2: b = a + 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      e = ref_model(op, a, b);
      run_op(op, a, b, 2, $urandom_range(0, 3), r, lat, rc, v, t);
      tests++;
      if (t !== 1'b0 || r !== e || v != 0 || rc != lat - 1) begin
        fails++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got %h viol=%0d, required %h", i, op, a, b, r, v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulhu_ones();
    test_div_vectors();
    test_grant_toggle();
    test_reset_midcalc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
